// File: rtl/hcordic_issue_scheduler_if.sv
// Request / issue / completion / response bundle around the HCORDIC issue scheduler.
// slave = scheduler side, master = requesters plus pipeline side.
interface hcordic_issue_scheduler_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_data;
    logic [1:0]  req0_mode;
    logic        req0_operation;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_data;
    logic [1:0]  req1_mode;
    logic        req1_operation;

    logic        issue_valid;
    logic [31:0] issue_data;
    logic [1:0]  issue_mode;
    logic        issue_operation;
    logic [7:0]  issue_tag;

    logic        done_valid;
    logic [7:0]  done_tag;
    logic [31:0] done_result;

    logic        rsp0_valid;
    logic [7:0]  rsp0_tag;
    logic [31:0] rsp0_result;
    logic        rsp1_valid;
    logic [7:0]  rsp1_tag;
    logic [31:0] rsp1_result;

    modport slave (
        input  req0_valid, req0_data, req0_mode, req0_operation,
        input  req1_valid, req1_data, req1_mode, req1_operation,
        output req0_ready, req1_ready,
        output issue_valid, issue_data, issue_mode, issue_operation, issue_tag,
        input  done_valid, done_tag, done_result,
        output rsp0_valid, rsp0_tag, rsp0_result,
        output rsp1_valid, rsp1_tag, rsp1_result
    );

    modport master (
        output req0_valid, req0_data, req0_mode, req0_operation,
        output req1_valid, req1_data, req1_mode, req1_operation,
        input  req0_ready, req1_ready,
        input  issue_valid, issue_data, issue_mode, issue_operation, issue_tag,
        output done_valid, done_tag, done_result,
        input  rsp0_valid, rsp0_tag, rsp0_result,
        input  rsp1_valid, rsp1_tag, rsp1_result
    );
endinterface

// File: rtl/hcordic_issue_scheduler.sv
// Two-requester issue scheduler and InsTag tracker in front of the HCORDIC pipeline.
// Define HCORDIC_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module hcordic_issue_scheduler #(
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    hcordic_issue_scheduler_if.slave    bus,
    output logic [7:0]                  inflight_count,
    output logic                        err_unknown_tag,
    output logic                        busy
);
    localparam int         DATA_W  = 32;
    localparam logic [7:0] MAX_CNT = 8'(MAX_INFLIGHT);

    logic [7:0]        next_tag;
    logic [255:0]      tag_valid;
    logic [255:0]      tag_owner;
    logic              can_issue;
    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic              done_hit;
    logic              done_miss;
    logic              done_owner;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_mode;
    logic              sel_op;

    logic              issue_vld_p1;
    logic [DATA_W-1:0] issue_data_p1;
    logic [1:0]        issue_mode_p1;
    logic              issue_op_p1;
    logic [7:0]        issue_tag_p1;
    logic              rsp0_vld_p1;
    logic [7:0]        rsp0_tag_p1;
    logic [DATA_W-1:0] rsp0_res_p1;
    logic              rsp1_vld_p1;
    logic [7:0]        rsp1_tag_p1;
    logic [DATA_W-1:0] rsp1_res_p1;

    // Occupancy update that can never wrap in either direction.
    function automatic logic [7:0] count_update(input logic [7:0] cnt, input logic inc, input logic dec);
        if (inc && !dec && cnt != 8'hFF) return cnt + 8'd1;
        if (dec && !inc && cnt != 8'h00) return cnt - 8'd1;
        return cnt;
    endfunction

`ifndef HCORDIC_SCHED_FIXED_PRIO_EN
    // Requester that wins the next tie; flips away from whoever was just served.
    logic rr_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rr_next <= 1'b0;
        else if (accept) rr_next <= gnt0;
    end
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef HCORDIC_SCHED_FIXED_PRIO_EN
            gnt0 = 1'b1;
`else
            gnt0 = !rr_next;
            gnt1 = rr_next;
`endif
        end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
        end
    end

    // A wrapped tag that is still outstanding blocks issue just like a full window.
    assign can_issue      = (inflight_count < MAX_CNT) && !tag_valid[next_tag];
    assign bus.req0_ready = reset_n && can_issue && gnt0;
    assign bus.req1_ready = reset_n && can_issue && gnt1;
    assign accept         = bus.req0_ready || bus.req1_ready;

    assign sel_data   = gnt1 ? bus.req1_data      : bus.req0_data;
    assign sel_mode   = gnt1 ? bus.req1_mode      : bus.req0_mode;
    assign sel_op     = gnt1 ? bus.req1_operation : bus.req0_operation;

    assign done_hit   = bus.done_valid && tag_valid[bus.done_tag];
    assign done_miss  = bus.done_valid && !tag_valid[bus.done_tag];
    assign done_owner = tag_owner[bus.done_tag];

    // Owner bits are only read behind tag_valid, so they need no reset.
    always_ff @(posedge clock) begin
        if (accept) tag_owner[next_tag] <= gnt1;
    end

    // Stage p1: registered issue strobe, responses and tracking state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            next_tag        <= '0;
            tag_valid       <= '0;
            inflight_count  <= '0;
            err_unknown_tag <= 1'b0;
            issue_vld_p1    <= 1'b0;
            issue_data_p1   <= '0;
            issue_mode_p1   <= '0;
            issue_op_p1     <= 1'b0;
            issue_tag_p1    <= '0;
            rsp0_vld_p1     <= 1'b0;
            rsp0_tag_p1     <= '0;
            rsp0_res_p1     <= '0;
            rsp1_vld_p1     <= 1'b0;
            rsp1_tag_p1     <= '0;
            rsp1_res_p1     <= '0;
        end else begin
            issue_vld_p1 <= accept;
            if (accept) begin
                issue_data_p1       <= sel_data;
                issue_mode_p1       <= sel_mode;
                issue_op_p1         <= sel_op;
                issue_tag_p1        <= next_tag;
                tag_valid[next_tag] <= 1'b1;
                next_tag            <= next_tag + 8'd1;
            end
            if (done_hit) tag_valid[bus.done_tag] <= 1'b0;

            rsp0_vld_p1 <= done_hit && !done_owner;
            rsp1_vld_p1 <= done_hit && done_owner;
            if (done_hit && !done_owner) begin
                rsp0_tag_p1 <= bus.done_tag;
                rsp0_res_p1 <= bus.done_result;
            end
            if (done_hit && done_owner) begin
                rsp1_tag_p1 <= bus.done_tag;
                rsp1_res_p1 <= bus.done_result;
            end

            if (done_miss) err_unknown_tag <= 1'b1;
            inflight_count <= count_update(inflight_count, accept, done_hit);
        end
    end

    assign bus.issue_valid     = issue_vld_p1;
    assign bus.issue_data      = issue_data_p1;
    assign bus.issue_mode      = issue_mode_p1;
    assign bus.issue_operation = issue_op_p1;
    assign bus.issue_tag       = issue_tag_p1;
    assign bus.rsp0_valid      = rsp0_vld_p1;
    assign bus.rsp0_tag        = rsp0_tag_p1;
    assign bus.rsp0_result     = rsp0_res_p1;
    assign bus.rsp1_valid      = rsp1_vld_p1;
    assign bus.rsp1_tag        = rsp1_tag_p1;
    assign bus.rsp1_result     = rsp1_res_p1;
    assign busy                = (inflight_count != 8'd0);
endmodule

// File: tb/tb_hcordic_issue_scheduler.sv
// Self-checking bench for hcordic_issue_scheduler: directed scenarios plus random traffic
// against an outstanding-tag scoreboard model.
module tb_hcordic_issue_scheduler;
    localparam int MAXI = 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] inflight_count;
    logic       err_unknown_tag;
    logic       busy;

    always #5 clock = ~clock;

    hcordic_issue_scheduler_if ifc ();

    hcordic_issue_scheduler #(.MAX_INFLIGHT(MAXI)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus            (ifc),
        .inflight_count (inflight_count),
        .err_unknown_tag(err_unknown_tag),
        .busy           (busy)
    );

    // Scoreboard: outstanding tag -> owner, plus next tag and tie-winner
    int          m_own[int];
    int          m_next;
    int          m_prio;
    bit          m_err;
    bit          e_rdy0, e_rdy1, e_iv, e_r0v, e_r1v, e_iop;
    logic [7:0]  e_itag, e_rtag;
    logic [31:0] e_idata, e_rres;
    logic [1:0]  e_imode;
    int          e_cnt;
    logic        obs_rdy0, obs_rdy1;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic clear_inputs();
        ifc.req0_valid = 0; ifc.req0_data = '0; ifc.req0_mode = '0; ifc.req0_operation = 0;
        ifc.req1_valid = 0; ifc.req1_data = '0; ifc.req1_mode = '0; ifc.req1_operation = 0;
        ifc.done_valid = 0; ifc.done_tag = '0; ifc.done_result = '0;
    endtask

    task automatic model_reset();
        m_own.delete();
        m_next = 0; m_prio = 0; m_err = 0;
        e_iv = 0; e_r0v = 0; e_r1v = 0; e_cnt = 0;
    endtask

    task automatic rand_req();
        ifc.req0_data = $urandom; ifc.req0_mode = 2'($urandom); ifc.req0_operation = 1'($urandom);
        ifc.req1_data = $urandom; ifc.req1_mode = 2'($urandom); ifc.req1_operation = 1'($urandom);
    endtask

    // One clock: decide from current inputs, sample readys, advance model, return #1 after edge.
    task automatic tick();
        int g;
        bit can, hit;
        int dt;
        @(negedge clock);
        can = (m_own.num() < MAXI) && !m_own.exists(m_next);
        g = -1;
        if (ifc.req0_valid && ifc.req1_valid) begin
`ifdef HCORDIC_SCHED_FIXED_PRIO_EN
            g = 0;
`else
            g = m_prio;
`endif
        end else if (ifc.req0_valid) g = 0;
        else if (ifc.req1_valid) g = 1;
        e_rdy0 = can && g == 0;
        e_rdy1 = can && g == 1;
        obs_rdy0 = ifc.req0_ready;
        obs_rdy1 = ifc.req1_ready;
        dt  = int'(ifc.done_tag);
        hit = ifc.done_valid && m_own.exists(dt);
        e_r0v = 0; e_r1v = 0;
        if (hit) begin
            e_r0v = (m_own[dt] == 0);
            e_r1v = (m_own[dt] == 1);
            e_rtag = ifc.done_tag;
            e_rres = ifc.done_result;
            m_own.delete(dt);
        end
        if (ifc.done_valid && !hit) m_err = 1;
        e_iv = can && g >= 0;
        if (e_iv) begin
            e_itag  = 8'(m_next);
            e_idata = (g == 0) ? ifc.req0_data : ifc.req1_data;
            e_imode = (g == 0) ? ifc.req0_mode : ifc.req1_mode;
            e_iop   = (g == 0) ? ifc.req0_operation : ifc.req1_operation;
            m_own[m_next] = g;
            m_next = (m_next + 1) % 256;
            m_prio = 1 - g;
        end
        e_cnt = m_own.num();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        ifc.req0_valid = 1; ifc.req1_valid = 1;
        repeat (2) @(posedge clock);
        #2;
        n_checks++;
        if ({ifc.req0_ready, ifc.req1_ready, ifc.issue_valid, ifc.rsp0_valid, ifc.rsp1_valid, err_unknown_tag, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got %b want 0000000", {ifc.req0_ready, ifc.req1_ready, ifc.issue_valid, ifc.rsp0_valid, ifc.rsp1_valid, err_unknown_tag, busy});
        end
        n_checks++;
        if ({inflight_count, ifc.issue_tag, ifc.issue_data, ifc.rsp0_tag, ifc.rsp1_result} !== 88'd0) begin
            n_fail++;
            $display("FAIL reset_values cnt=%0d tag=%0d data=%h want all zero", inflight_count, ifc.issue_tag, ifc.issue_data);
        end
        apply_reset();
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 20; i++) begin
            ifc.req0_valid = 1; ifc.req1_valid = 1; rand_req();
            tick();
            n_checks++;
            if ({obs_rdy0, obs_rdy1} !== {e_rdy0, e_rdy1} || ifc.issue_valid !== e_iv || inflight_count !== 8'(e_cnt)) begin
                n_fail++;
                $display("FAIL alt_model cyc=%0d rdy=%b%b iv=%b cnt=%0d want rdy=%b%b iv=%b cnt=%0d", i, obs_rdy0, obs_rdy1, ifc.issue_valid, inflight_count, e_rdy0, e_rdy1, e_iv, e_cnt);
            end
            if (i < 16) begin
                n_checks++;
                if (ifc.issue_tag !== 8'(i) || {obs_rdy0, obs_rdy1} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || ifc.issue_data !== e_idata) begin
                    n_fail++;
                    $display("FAIL alt_issue cyc=%0d tag=%0d rdy=%b%b want tag=%0d owner=%0d", i, ifc.issue_tag, obs_rdy0, obs_rdy1, i, i % 2);
                end
            end else begin
                n_checks++;
                if ({obs_rdy0, obs_rdy1} !== 2'b00 || inflight_count !== 8'd16 || (i > 16 && ifc.issue_valid !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL alt_full cyc=%0d rdy=%b%b cnt=%0d iv=%b want rdy=00 cnt=16", i, obs_rdy0, obs_rdy1, inflight_count, ifc.issue_valid);
                end
            end
        end
    endtask

    task automatic test_credit_release();
        logic [31:0] r;
        r = $urandom;
        ifc.done_valid = 1; ifc.done_tag = 8'd5; ifc.done_result = r;
        tick();
        n_checks++;
        if ({ifc.rsp0_valid, ifc.rsp1_valid} !== 2'b01 || ifc.rsp1_tag !== 8'd5 || ifc.rsp1_result !== r || inflight_count !== 8'd15 || {obs_rdy0, obs_rdy1} !== 2'b00) begin
            n_fail++;
            $display("FAIL credit_rsp rsp=%b%b tag=%0d res=%h cnt=%0d want rsp=01 tag=5 res=%h cnt=15", ifc.rsp0_valid, ifc.rsp1_valid, ifc.rsp1_tag, ifc.rsp1_result, inflight_count, r);
        end
        ifc.done_valid = 0;
        tick();
        n_checks++;
        if ({obs_rdy0, obs_rdy1} !== {e_rdy0, e_rdy1} || {obs_rdy0, obs_rdy1} === 2'b00 || ifc.issue_valid !== 1'b1 || ifc.issue_tag !== 8'd16 || inflight_count !== 8'd16) begin
            n_fail++;
            $display("FAIL credit_reissue rdy=%b%b iv=%b tag=%0d cnt=%0d want one ready, tag=16 cnt=16", obs_rdy0, obs_rdy1, ifc.issue_valid, ifc.issue_tag, inflight_count);
        end
        tick();
        n_checks++;
        if ({obs_rdy0, obs_rdy1} !== 2'b00 || ifc.issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_refull rdy=%b%b iv=%b want 00 0", obs_rdy0, obs_rdy1, ifc.issue_valid);
        end
    endtask

    task automatic test_simultaneous();
        int q[$];
        ifc.req0_valid = 0; ifc.req1_valid = 0;
        ifc.done_valid = 1; ifc.done_tag = 8'd0; ifc.done_result = $urandom;
        tick();
        ifc.req0_valid = 1; ifc.req1_valid = 1; rand_req();
        ifc.done_tag = 8'd1; ifc.done_result = $urandom;
        tick();
        n_checks++;
        if (ifc.issue_valid !== 1'b1 || ifc.issue_tag !== 8'd17 || {ifc.rsp0_valid, ifc.rsp1_valid} !== 2'b01 || ifc.rsp1_tag !== 8'd1 || inflight_count !== 8'd15) begin
            n_fail++;
            $display("FAIL simul iv=%b tag=%0d rsp=%b%b rtag=%0d cnt=%0d want iv=1 tag=17 rsp=01 rtag=1 cnt=15", ifc.issue_valid, ifc.issue_tag, ifc.rsp0_valid, ifc.rsp1_valid, ifc.rsp1_tag, inflight_count);
        end
        ifc.req0_valid = 0; ifc.req1_valid = 0;
        foreach (m_own[k]) q.push_back(k);
        foreach (q[j]) begin
            ifc.done_valid = 1; ifc.done_tag = 8'(q[j]); ifc.done_result = $urandom;
            tick();
            n_checks++;
            if ({ifc.rsp0_valid, ifc.rsp1_valid} !== {e_r0v, e_r1v} || (e_r0v ? ifc.rsp0_tag : ifc.rsp1_tag) !== e_rtag || (e_r0v ? ifc.rsp0_result : ifc.rsp1_result) !== e_rres) begin
                n_fail++;
                $display("FAIL drain tag=%0d rsp=%b%b want %b%b", q[j], ifc.rsp0_valid, ifc.rsp1_valid, e_r0v, e_r1v);
            end
        end
        ifc.done_valid = 0;
        n_checks++;
        if (inflight_count !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty cnt=%0d busy=%b want 0 0", inflight_count, busy);
        end
    endtask

    task automatic test_unknown_tag();
        ifc.done_valid = 1; ifc.done_tag = 8'h40; ifc.done_result = $urandom;
        tick();
        n_checks++;
        if ({ifc.rsp0_valid, ifc.rsp1_valid} !== 2'b00 || err_unknown_tag !== 1'b1 || inflight_count !== 8'd0) begin
            n_fail++;
            $display("FAIL unknown_tag rsp=%b%b err=%b cnt=%0d want 00 1 0", ifc.rsp0_valid, ifc.rsp1_valid, err_unknown_tag, inflight_count);
        end
        ifc.done_valid = 0;
        repeat (3) tick();
        n_checks++;
        if (err_unknown_tag !== 1'b1) begin
            n_fail++;
            $display("FAIL unknown_sticky err=%b want 1", err_unknown_tag);
        end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        n_checks++;
        if (err_unknown_tag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clears_err err=%b want 0", err_unknown_tag);
        end
        ifc.req0_valid = 1;
        repeat (3) begin rand_req(); tick(); end
        n_checks++;
        if (inflight_count !== 8'd3 || ifc.issue_tag !== 8'd2) begin
            n_fail++;
            $display("FAIL midrst_fill cnt=%0d tag=%0d want 3 2", inflight_count, ifc.issue_tag);
        end
        ifc.req1_valid = 1;
        #2 reset_n = 0;
        #1;
        n_checks++;
        if ({ifc.req0_ready, ifc.req1_ready, ifc.issue_valid, busy} !== 4'b0 || {inflight_count, ifc.issue_tag, ifc.issue_data} !== 48'd0) begin
            n_fail++;
            $display("FAIL midrst_async rdy=%b%b iv=%b busy=%b cnt=%0d tag=%0d want all 0", ifc.req0_ready, ifc.req1_ready, ifc.issue_valid, busy, inflight_count, ifc.issue_tag);
        end
        clear_inputs();
        model_reset();
        @(negedge clock) reset_n = 1;
        @(posedge clock);
        #1;
        ifc.done_valid = 1; ifc.done_tag = 8'd1; ifc.done_result = $urandom;
        tick();
        n_checks++;
        if (err_unknown_tag !== 1'b1 || {ifc.rsp0_valid, ifc.rsp1_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_stale err=%b rsp=%b%b want 1 00", err_unknown_tag, ifc.rsp0_valid, ifc.rsp1_valid);
        end
        ifc.done_valid = 0; ifc.req1_valid = 1; rand_req();
        tick();
        n_checks++;
        if (ifc.issue_valid !== 1'b1 || ifc.issue_tag !== 8'd0 || inflight_count !== 8'd1 || ifc.issue_data !== e_idata) begin
            n_fail++;
            $display("FAIL midrst_reissue iv=%b tag=%0d cnt=%0d want 1 0 1", ifc.issue_valid, ifc.issue_tag, inflight_count);
        end
        clear_inputs();
    endtask

    task automatic test_tag_wrap();
        apply_reset();
        ifc.req0_valid = 1; rand_req();
        tick();
        for (int k = 1; k < 256; k++) begin
            ifc.req0_valid = 1; ifc.req1_valid = 1'($urandom); rand_req();
            ifc.done_valid = (k >= 2); ifc.done_tag = 8'(k - 1); ifc.done_result = $urandom;
            tick();
            n_checks++;
            if (ifc.issue_valid !== 1'b1 || ifc.issue_tag !== 8'(k) || ifc.issue_data !== e_idata || inflight_count !== 8'(e_cnt)
                || {ifc.rsp0_valid, ifc.rsp1_valid} !== {e_r0v, e_r1v}) begin
                n_fail++;
                $display("FAIL wrap_issue k=%0d iv=%b tag=%0d cnt=%0d want tag=%0d cnt=%0d", k, ifc.issue_valid, ifc.issue_tag, inflight_count, k, e_cnt);
            end
        end
        for (int k = 0; k < 4; k++) begin
            ifc.done_valid = (k == 0) || (k == 3);
            ifc.done_tag = (k == 0) ? 8'd255 : 8'd0;
            tick();
            n_checks++;
            if ({obs_rdy0, obs_rdy1} !== 2'b00 || ifc.issue_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_block k=%0d rdy=%b%b iv=%b want 00 0", k, obs_rdy0, obs_rdy1, ifc.issue_valid);
            end
        end
        ifc.done_valid = 0;
        tick();
        n_checks++;
        if ({obs_rdy0, obs_rdy1} === 2'b00 || ifc.issue_valid !== 1'b1 || ifc.issue_tag !== 8'd0 || inflight_count !== 8'd1) begin
            n_fail++;
            $display("FAIL wrap_release rdy=%b%b iv=%b tag=%0d cnt=%0d want ready, tag=0 cnt=1", obs_rdy0, obs_rdy1, ifc.issue_valid, ifc.issue_tag, inflight_count);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int q[$];
        int r;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            ifc.req0_valid = 1'($urandom); ifc.req1_valid = 1'($urandom); rand_req();
            q.delete();
            foreach (m_own[k]) q.push_back(k);
            r = $urandom_range(99);
            ifc.done_valid = 0; ifc.done_result = $urandom;
            if (r < 40 && q.size() > 0) begin
                ifc.done_valid = 1; ifc.done_tag = 8'(q[$urandom_range(q.size() - 1)]);
            end else if (r < 44) begin
                ifc.done_valid = 1; ifc.done_tag = 8'($urandom);
            end
            tick();
            n_checks++;
            if ({obs_rdy0, obs_rdy1} !== {e_rdy0, e_rdy1}) begin
                n_fail++;
                $display("FAIL rnd_ready c=%0d got %b%b want %b%b", c, obs_rdy0, obs_rdy1, e_rdy0, e_rdy1);
            end
            n_checks++;
            if ({ifc.issue_valid, ifc.rsp0_valid, ifc.rsp1_valid, err_unknown_tag, busy} !== {e_iv, e_r0v, e_r1v, m_err, e_cnt != 0} || inflight_count !== 8'(e_cnt)) begin
                n_fail++;
                $display("FAIL rnd_ctrl c=%0d got iv/r0/r1/err/busy=%b%b%b%b%b cnt=%0d want %b%b%b%b%b cnt=%0d", c, ifc.issue_valid, ifc.rsp0_valid, ifc.rsp1_valid, err_unknown_tag, busy, inflight_count, e_iv, e_r0v, e_r1v, m_err, e_cnt != 0, e_cnt);
            end
            if (e_iv) begin
                n_checks++;
                if ({ifc.issue_tag, ifc.issue_data, ifc.issue_mode, ifc.issue_operation} !== {e_itag, e_idata, e_imode, e_iop}) begin
                    n_fail++;
                    $display("FAIL rnd_issue c=%0d tag=%0d data=%h mode=%b op=%b want %0d %h %b %b", c, ifc.issue_tag, ifc.issue_data, ifc.issue_mode, ifc.issue_operation, e_itag, e_idata, e_imode, e_iop);
                end
            end
            if (e_r0v || e_r1v) begin
                n_checks++;
                if ((e_r0v ? {ifc.rsp0_tag, ifc.rsp0_result} : {ifc.rsp1_tag, ifc.rsp1_result}) !== {e_rtag, e_rres}) begin
                    n_fail++;
                    $display("FAIL rnd_rsp c=%0d rsp0=%0d/%h rsp1=%0d/%h want %0d/%h", c, ifc.rsp0_tag, ifc.rsp0_result, ifc.rsp1_tag, ifc.rsp1_result, e_rtag, e_rres);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 0;
        clear_inputs();
        model_reset();
        test_reset();
        test_alternating();
        test_credit_release();
        test_simultaneous();
        test_unknown_tag();
        test_reset_mid_op();
        test_tag_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
